// File: rtl/io_bus_cycle_arbiter_if.sv
// Bus bundle for the two-requester 8086-style bus cycle arbiter.
// The master side is the arbiter; the slave side is the requesters and bus devices.
interface io_bus_cycle_arbiter_if;
  logic [1:0]  REQ;
  logic [1:0]  REQ_WR;
  logic [1:0]  REQ_IOM;
  logic [19:0] REQ_ADDR0;
  logic [19:0] REQ_ADDR1;
  logic [7:0]  REQ_WDATA0;
  logic [7:0]  REQ_WDATA1;
  logic [1:0]  GNT;
  logic [1:0]  DONE;
  logic [7:0]  RDATA;
  logic        ERR;
  logic        ALE;
  logic [19:0] Address;
  logic        IOM;
  logic        RD;
  logic        WR;
  logic        CS_MEM;
  logic        CS_IO;
  logic [7:0]  DataOut;
  logic        DataOE;
  logic [7:0]  DataIn;

  modport master (
    input  REQ, REQ_WR, REQ_IOM,
    input  REQ_ADDR0, REQ_ADDR1,
    input  REQ_WDATA0, REQ_WDATA1,
    input  DataIn,
    output GNT, DONE, RDATA, ERR,
    output ALE, Address, IOM, RD, WR,
    output CS_MEM, CS_IO, DataOut, DataOE
  );

  modport slave (
    output REQ, REQ_WR, REQ_IOM,
    output REQ_ADDR0, REQ_ADDR1,
    output REQ_WDATA0, REQ_WDATA1,
    output DataIn,
    input  GNT, DONE, RDATA, ERR,
    input  ALE, Address, IOM, RD, WR,
    input  CS_MEM, CS_IO, DataOut, DataOE
  );
endinterface

// File: rtl/io_bus_cycle_arbiter.sv
// Round-robin arbiter running T1..T4 multiplexed bus cycles
// for a CPU (REQ[0]) and a DMA engine (REQ[1]).
module io_bus_cycle_arbiter #(
  parameter logic        VALID     = 1'b1,
  parameter logic [19:0] MEM_BASE  = 20'h00D00,
  parameter logic [19:0] MEM_LIMIT = 20'h01C00,
  parameter logic [19:0] IO_BASE   = 20'h0F000,
  parameter logic [19:0] IO_LIMIT  = 20'h0F0FF
) (
  input  logic CLK,
  input  logic RESET,
  io_bus_cycle_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, T1, T2, T3, T4
  } state_e;

  state_e      state_q;
  logic        ptr_q;
  logic        wr_q;
  logic        miss_q;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [7:0]  rdata_q;
  logic        err_q;
  logic        ale_q;
  logic [19:0] addr_q;
  logic        iom_q;
  logic        rd_q;
  logic        wrs_q;
  logic        cs_mem_q;
  logic        cs_io_q;
  logic [7:0]  dout_q;
  logic        oe_q;

  logic        win_d;
  logic [19:0] addr_d;
  logic        iom_d;
  logic        wr_d;
  logic [7:0]  wdata_d;
  logic        cs_mem_d;
  logic        cs_io_d;

  // Preferred requester wins if asking, else the other one
  always_comb begin
    win_d    = bus.REQ[ptr_q] ? ptr_q : ~ptr_q;
    addr_d   = win_d ? bus.REQ_ADDR1 : bus.REQ_ADDR0;
    wdata_d  = win_d ? bus.REQ_WDATA1 : bus.REQ_WDATA0;
    iom_d    = bus.REQ_IOM[win_d];
    wr_d     = bus.REQ_WR[win_d];
    cs_mem_d = !iom_d && (addr_d >= MEM_BASE)
               && (addr_d <= MEM_LIMIT);
    cs_io_d  = iom_d && (addr_d >= IO_BASE)
               && (addr_d <= IO_LIMIT);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      wr_q     <= 1'b0;
      miss_q   <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata_q  <= 8'h00;
      err_q    <= 1'b0;
      ale_q    <= 1'b0;
      addr_q   <= 20'h0;
      iom_q    <= ~VALID;
      rd_q     <= 1'b1;
      wrs_q    <= 1'b1;
      cs_mem_q <= 1'b0;
      cs_io_q  <= 1'b0;
      dout_q   <= 8'h00;
      oe_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.REQ) begin
            state_q  <= T1;
            ptr_q    <= ~win_d;
            gnt_q    <= win_d ? 2'b10 : 2'b01;
            ale_q    <= 1'b1;
            addr_q   <= addr_d;
            iom_q    <= iom_d ? VALID : ~VALID;
            wr_q     <= wr_d;
            dout_q   <= wdata_d;
            cs_mem_q <= cs_mem_d;
            cs_io_q  <= cs_io_d;
            miss_q   <= !(cs_mem_d || cs_io_d);
          end
        end
        T1: begin
          state_q <= T2;
          ale_q   <= 1'b0;
          rd_q    <= wr_q;
          wrs_q   <= ~wr_q;
          oe_q    <= wr_q;
        end
        T2: state_q <= T3;
        T3: begin
          state_q <= T4;
          rd_q    <= 1'b1;
          wrs_q   <= 1'b1;
          oe_q    <= 1'b0;
          done_q  <= gnt_q;
          err_q   <= miss_q;
          // Unclaimed reads float high on the bus
          if (!wr_q)
            rdata_q <= miss_q ? 8'hFF : bus.DataIn;
        end
        T4: begin
          state_q  <= IDLE;
          done_q   <= 2'b00;
          err_q    <= 1'b0;
          gnt_q    <= 2'b00;
          cs_mem_q <= 1'b0;
          cs_io_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.DONE    = done_q;
  assign bus.RDATA   = rdata_q;
  assign bus.ERR     = err_q;
  assign bus.ALE     = ale_q;
  assign bus.Address = addr_q;
  assign bus.IOM     = iom_q;
  assign bus.RD      = rd_q;
  assign bus.WR      = wrs_q;
  assign bus.CS_MEM  = cs_mem_q;
  assign bus.CS_IO   = cs_io_q;
  assign bus.DataOut = dout_q;
  assign bus.DataOE  = oe_q;

endmodule
